// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state encoding, syscall codes and PC target helpers
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [31:0] SYSCALL_EXIT = 32'd10;
  localparam logic [31:0] SYSCALL_DISP = 32'd34;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  function automatic logic [31:0] jump_target(input logic [3:0] pc_hi, input logic [25:0] idx);
    return {pc_hi, idx, 2'b00};
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4, input logic [15:0] imm);
    return pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/event_counter.sv
// rtl/event_counter.sv - 32-bit wrapping event counter with freeze
module event_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        freeze_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !freeze_i) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_seq_ctrl.sv
// rtl/fetch_seq_ctrl.sv - PC owner, next-PC selection, run/pause/halt control and counters
module fetch_seq_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEF,
  parameter int          IM_AW         = 12,
  parameter bit          PAUSE_ON_DISP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [31:0]      instr,
  input  logic             branch_taken,
  input  logic             is_jump,
  input  logic             is_jr,
  input  logic [31:0]      jr_target,
  input  logic             is_syscall,
  input  logic [31:0]      v0,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [IM_AW-1:0] im_addr,
  output logic             commit,
  output logic             disp_strobe,
  output logic             halted,
  output logic [31:0]      cycle_cnt,
  output logic [31:0]      jump_cnt,
  output logic [31:0]      branch_cnt
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_w;
  logic        cycle_inc, jump_inc, branch_inc;
  logic        unused_instr;

  assign pc_plus4_w   = pc_q + 32'd4;
  assign unused_instr = ^instr[31:26];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    commit      = 1'b0;
    disp_strobe = 1'b0;
    cycle_inc   = 1'b0;
    jump_inc    = 1'b0;
    branch_inc  = 1'b0;
    case (state_q)
      ST_IDLE: if (go) state_d = ST_RUN;
      ST_RUN: begin
        commit    = 1'b1;
        cycle_inc = 1'b1;
        // Exit retires but leaves the PC on the syscall so the board shows where it stopped.
        if (is_syscall && v0 == SYSCALL_EXIT) begin
          state_d = ST_HALT;
        end else if (is_jr) begin
          pc_d     = jr_target;
          jump_inc = 1'b1;
        end else if (is_jump) begin
          pc_d     = jump_target(pc_plus4_w[31:28], instr[25:0]);
          jump_inc = 1'b1;
        end else if (branch_taken) begin
          pc_d       = branch_target(pc_plus4_w, instr[15:0]);
          branch_inc = 1'b1;
        end else begin
          pc_d = pc_plus4_w;
          if (is_syscall && v0 == SYSCALL_DISP) begin
            disp_strobe = 1'b1;
            if (PAUSE_ON_DISP) state_d = ST_PAUSE;
          end
        end
      end
      ST_PAUSE: if (go) state_d = ST_RUN;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign halted   = (state_q == ST_HALT);
  assign pc       = pc_q;
  assign pc_plus4 = pc_plus4_w;
  assign im_addr  = pc_q[IM_AW-1:0];

  event_counter u_cycle_cnt (
    .clk(clk), .rst(rst), .inc_i(cycle_inc), .freeze_i(halted), .cnt_o(cycle_cnt)
  );

  event_counter u_jump_cnt (
    .clk(clk), .rst(rst), .inc_i(jump_inc), .freeze_i(halted), .cnt_o(jump_cnt)
  );

  event_counter u_branch_cnt (
    .clk(clk), .rst(rst), .inc_i(branch_inc), .freeze_i(halted), .cnt_o(branch_cnt)
  );

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb/tb_fetch_seq_ctrl.sv - scoreboard bench for fetch_seq_ctrl
module tb_fetch_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [31:0] instr = '0;
  logic        branch_taken = 1'b0;
  logic        is_jump = 1'b0;
  logic        is_jr = 1'b0;
  logic [31:0] jr_target = '0;
  logic        is_syscall = 1'b0;
  logic [31:0] v0 = '0;
  logic [31:0] pc, pc_plus4, cycle_cnt, jump_cnt, branch_cnt;
  logic [11:0] im_addr;
  logic        commit, disp_strobe, halted;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_j = '0, m_b = '0, m_c = '0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] jc;
    logic [31:0] bc;
    logic [31:0] cc;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [31:0] ins;
    logic        bt;
    logic        j;
    logic        jr;
    logic [31:0] jrt;
    logic        sc;
    logic [31:0] v;
    logic [31:0] epc;
    logic [31:0] dj;
    logic [31:0] db;
  } cyc_t;

  fetch_seq_ctrl dut (
    .clk(clk), .rst(rst), .go(go), .instr(instr), .branch_taken(branch_taken),
    .is_jump(is_jump), .is_jr(is_jr), .jr_target(jr_target), .is_syscall(is_syscall),
    .v0(v0), .pc(pc), .pc_plus4(pc_plus4), .im_addr(im_addr), .commit(commit),
    .disp_strobe(disp_strobe), .halted(halted), .cycle_cnt(cycle_cnt),
    .jump_cnt(jump_cnt), .branch_cnt(branch_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input cyc_t c);
    instr        = c.ins;
    branch_taken = c.bt;
    is_jump      = c.j;
    is_jr        = c.jr;
    jr_target    = c.jrt;
    is_syscall   = c.sc;
    v0           = c.v;
  endtask

  function automatic cyc_t nop(input logic [31:0] epc);
    return '{32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, epc, 32'd0, 32'd0};
  endfunction

  function automatic cyc_t jr_to(input logic [31:0] t);
    return '{32'h0, 1'b0, 1'b0, 1'b1, t, 1'b0, 32'h0, t, 32'd1, 32'd0};
  endfunction

  task automatic test_reset();
    #12;
    checks++;
    if ({pc, pc_plus4, im_addr, cycle_cnt, jump_cnt, branch_cnt, commit, disp_strobe, halted} !==
        {32'h3000, 32'h3004, 12'h000, 96'h0, 3'b000}) begin
      errors++;
      $display("FAIL reset_state got pc=%h im=%h c=%0d j=%0d b=%0d cm=%b ds=%b h=%b expected pc=00003000 im=000 zeros",
               pc, im_addr, cycle_cnt, jump_cnt, branch_cnt, commit, disp_strobe, halted);
    end
    rst = 1'b0;
    repeat (3) step();
    checks++;
    if ({pc, commit, cycle_cnt} !== {32'h3000, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL idle_hold got pc=%h commit=%b c=%0d expected pc=00003000 commit=0 c=0", pc, commit, cycle_cnt);
    end
  endtask

  task automatic test_jump();
    exp_t e;
    go = 1'b1;
    drive('{32'h08000c05, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h3014, 32'd1, 32'd0});
    step();
    checks++;
    if ({pc, commit, cycle_cnt, jump_cnt} !== {32'h3000, 1'b1, 32'h0, 32'h0}) begin
      errors++;
      $display("FAIL idle_to_run got pc=%h commit=%b c=%0d j=%0d expected pc=00003000 commit=1 c=0 j=0",
               pc, commit, cycle_cnt, jump_cnt);
    end
    m_j = m_j + 32'd1;
    m_c = m_c + 32'd1;
    sbq.push_back('{32'h3014, m_j, m_b, m_c});
    step();
    e = sbq.pop_front();
    checks++;
    if ({pc, jump_cnt, branch_cnt, cycle_cnt, im_addr} !== {e.pc, e.jc, e.bc, e.cc, 12'h014}) begin
      errors++;
      $display("FAIL jump got pc=%h im=%h j=%0d b=%0d c=%0d expected pc=%h im=014 j=%0d b=%0d c=%0d",
               pc, im_addr, jump_cnt, branch_cnt, cycle_cnt, e.pc, e.jc, e.bc, e.cc);
    end
  endtask

  task automatic test_jr_and_wrap();
    exp_t e;
    cyc_t t[5];
    t[0] = '{32'h08000c05, 1'b1, 1'b1, 1'b1, 32'h3010, 1'b0, 32'h0, 32'h3010, 32'd1, 32'd0};
    t[1] = jr_to(32'hFFFF_FFFC);
    t[2] = nop(32'h0000_0000);
    t[3] = nop(32'h0000_0004);
    t[4] = jr_to(32'h0000_3164);
    foreach (t[i]) begin
      drive(t[i]);
      m_j = m_j + t[i].dj;
      m_b = m_b + t[i].db;
      m_c = m_c + 32'd1;
      sbq.push_back('{t[i].epc, m_j, m_b, m_c});
      step();
      e = sbq.pop_front();
      checks++;
      if ({pc, jump_cnt, branch_cnt, cycle_cnt, im_addr} !== {e.pc, e.jc, e.bc, e.cc, e.pc[11:0]}) begin
        errors++;
        $display("FAIL jr_wrap[%0d] got pc=%h im=%h j=%0d b=%0d c=%0d expected pc=%h j=%0d b=%0d c=%0d",
                 i, pc, im_addr, jump_cnt, branch_cnt, cycle_cnt, e.pc, e.jc, e.bc, e.cc);
      end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    cyc_t t[4];
    t[0] = '{32'h1500fff9, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h314C, 32'd0, 32'd1};
    t[1] = jr_to(32'h0000_3164);
    t[2] = '{32'h1500fff9, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h3168, 32'd0, 32'd0};
    t[3] = '{32'h10000010, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h31AC, 32'd0, 32'd1};
    foreach (t[i]) begin
      drive(t[i]);
      m_j = m_j + t[i].dj;
      m_b = m_b + t[i].db;
      m_c = m_c + 32'd1;
      sbq.push_back('{t[i].epc, m_j, m_b, m_c});
      step();
      e = sbq.pop_front();
      checks++;
      if ({pc, jump_cnt, branch_cnt, cycle_cnt} !== {e.pc, e.jc, e.bc, e.cc}) begin
        errors++;
        $display("FAIL branch[%0d] got pc=%h j=%0d b=%0d c=%0d expected pc=%h j=%0d b=%0d c=%0d",
                 i, pc, jump_cnt, branch_cnt, cycle_cnt, e.pc, e.jc, e.bc, e.cc);
      end
    end
  endtask

  task automatic test_disp_pause();
    exp_t e;
    drive('{32'h0000000c, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'd4, 32'h31B0, 32'd0, 32'd0});
    #1;
    checks++;
    if ({disp_strobe, commit} !== 2'b01) begin
      errors++;
      $display("FAIL other_syscall got ds=%b cm=%b expected ds=0 cm=1", disp_strobe, commit);
    end
    m_c = m_c + 32'd1;
    sbq.push_back('{32'h31B0, m_j, m_b, m_c});
    step();
    e = sbq.pop_front();
    checks++;
    if ({pc, cycle_cnt, commit} !== {e.pc, e.cc, 1'b1}) begin
      errors++;
      $display("FAIL other_syscall_nop got pc=%h c=%0d cm=%b expected pc=%h c=%0d cm=1", pc, cycle_cnt, commit, e.pc, e.cc);
    end
    go = 1'b0;
    v0 = 32'd34;
    #1;
    checks++;
    if ({disp_strobe, commit} !== 2'b11) begin
      errors++;
      $display("FAIL disp_strobe got ds=%b cm=%b expected ds=1 cm=1", disp_strobe, commit);
    end
    m_c = m_c + 32'd1;
    sbq.push_back('{32'h31B4, m_j, m_b, m_c});
    step();
    e = sbq.pop_front();
    checks++;
    if ({pc, cycle_cnt, commit, disp_strobe} !== {e.pc, e.cc, 2'b00}) begin
      errors++;
      $display("FAIL disp_to_pause got pc=%h c=%0d cm=%b ds=%b expected pc=%h c=%0d cm=0 ds=0",
               pc, cycle_cnt, commit, disp_strobe, e.pc, e.cc);
    end
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if ({pc, cycle_cnt, commit, disp_strobe} !== {32'h31B4, m_c, 2'b00}) begin
        errors++;
        $display("FAIL pause_hold[%0d] got pc=%h c=%0d cm=%b ds=%b expected pc=000031b4 c=%0d cm=0 ds=0",
                 k, pc, cycle_cnt, commit, disp_strobe, m_c);
      end
    end
    go = 1'b1;
    drive(nop(32'h31B8));
    step();
    checks++;
    if ({pc, commit} !== {32'h31B4, 1'b1}) begin
      errors++;
      $display("FAIL pause_resume got pc=%h cm=%b expected pc=000031b4 cm=1", pc, commit);
    end
    m_c = m_c + 32'd1;
    sbq.push_back('{32'h31B8, m_j, m_b, m_c});
    step();
    e = sbq.pop_front();
    checks++;
    if ({pc, jump_cnt, branch_cnt, cycle_cnt} !== {e.pc, e.jc, e.bc, e.cc}) begin
      errors++;
      $display("FAIL resume_step got pc=%h c=%0d expected pc=%h c=%0d", pc, cycle_cnt, e.pc, e.cc);
    end
  endtask

  task automatic test_halt();
    exp_t e;
    drive(jr_to(32'h32D8));
    m_j = m_j + 32'd1;
    m_c = m_c + 32'd1;
    sbq.push_back('{32'h32D8, m_j, m_b, m_c});
    step();
    e = sbq.pop_front();
    checks++;
    if ({pc, jump_cnt, branch_cnt, cycle_cnt} !== {e.pc, e.jc, e.bc, e.cc}) begin
      errors++;
      $display("FAIL halt_setup got pc=%h j=%0d c=%0d expected pc=%h j=%0d c=%0d", pc, jump_cnt, cycle_cnt, e.pc, e.jc, e.cc);
    end
    drive('{32'h0000000c, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'd10, 32'h32D8, 32'd0, 32'd0});
    #1;
    checks++;
    if ({commit, disp_strobe, halted} !== 3'b100) begin
      errors++;
      $display("FAIL exit_retire got cm=%b ds=%b h=%b expected cm=1 ds=0 h=0", commit, disp_strobe, halted);
    end
    m_c = m_c + 32'd1;
    sbq.push_back('{32'h32D8, m_j, m_b, m_c});
    step();
    e = sbq.pop_front();
    checks++;
    if ({pc, jump_cnt, branch_cnt, cycle_cnt, halted, commit} !== {e.pc, e.jc, e.bc, e.cc, 2'b10}) begin
      errors++;
      $display("FAIL halt_enter got pc=%h j=%0d b=%0d c=%0d h=%b cm=%b expected pc=%h j=%0d b=%0d c=%0d h=1 cm=0",
               pc, jump_cnt, branch_cnt, cycle_cnt, halted, commit, e.pc, e.jc, e.bc, e.cc);
    end
    drive('{32'h08000c05, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0, 32'd0});
    for (int k = 0; k < 20; k++) begin
      step();
      checks++;
      if ({pc, jump_cnt, branch_cnt, cycle_cnt, halted, commit} !== {32'h32D8, m_j, m_b, m_c, 2'b10}) begin
        errors++;
        $display("FAIL halt_frozen[%0d] got pc=%h j=%0d b=%0d c=%0d h=%b expected pc=000032d8 j=%0d b=%0d c=%0d h=1",
                 k, pc, jump_cnt, branch_cnt, cycle_cnt, halted, m_j, m_b, m_c);
      end
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({pc, im_addr, jump_cnt, branch_cnt, cycle_cnt, halted, commit} !== {32'h3000, 12'h0, 96'h0, 2'b00}) begin
      errors++;
      $display("FAIL halt_reset got pc=%h j=%0d b=%0d c=%0d h=%b expected pc=00003000 zeros h=0",
               pc, jump_cnt, branch_cnt, cycle_cnt, halted);
    end
    m_j = '0;
    m_b = '0;
    m_c = '0;
    #1 rst = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    drive(nop(32'h0));
    go = 1'b1;
    step();
    for (int k = 1; k <= 2; k++) begin
      m_c = m_c + 32'd1;
      sbq.push_back('{32'h3000 + 32'(4 * k), m_j, m_b, m_c});
      step();
      e = sbq.pop_front();
      checks++;
      if ({pc, jump_cnt, branch_cnt, cycle_cnt} !== {e.pc, e.jc, e.bc, e.cc}) begin
        errors++;
        $display("FAIL post_reset_run[%0d] got pc=%h c=%0d expected pc=%h c=%0d", k, pc, cycle_cnt, e.pc, e.cc);
      end
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({pc, cycle_cnt, commit, disp_strobe, halted} !== {32'h3000, 32'h0, 3'b000}) begin
      errors++;
      $display("FAIL async_reset got pc=%h c=%0d cm=%b expected pc=00003000 c=0 cm=0", pc, cycle_cnt, commit);
    end
    go = 1'b0;
    #2 rst = 1'b0;
    repeat (3) step();
    checks++;
    if ({pc, cycle_cnt, commit} !== {32'h3000, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_idle got pc=%h c=%0d cm=%b expected pc=00003000 c=0 cm=0", pc, cycle_cnt, commit);
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_jr_and_wrap();
    test_branch();
    test_disp_pause();
    test_halt();
    test_async_reset();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
